// File: rtl/digital_playground_pkg.sv
// ---------------------------------------------------------------------------
// digital_playground_pkg
//
// Purpose: shared constants for the digital playground core. It holds the mode
// select codes, the ALU opcodes, the turn-signal direction codes, the RAM
// geometry and the 7-segment glyph table, plus two small lookup helpers.
//
// No ports (package).
// ---------------------------------------------------------------------------
package digital_playground_pkg;

    // Mode select codes on ui_in[2:0]
    localparam logic [2:0] MODE_GATES = 3'b000;
    localparam logic [2:0] MODE_MXD   = 3'b001;
    localparam logic [2:0] MODE_PWM   = 3'b010;
    localparam logic [2:0] MODE_HEX7  = 3'b011;
    localparam logic [2:0] MODE_ALU   = 3'b100;
    localparam logic [2:0] MODE_FDC   = 3'b101;
    localparam logic [2:0] MODE_RAM   = 3'b110;
    localparam logic [2:0] MODE_DIR   = 3'b111;

    // ALU opcodes on ui_in[5:3]
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Turn-signal direction codes on ui_in[4:3]
    localparam logic [1:0] DIR_OFF    = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_RIGHT  = 2'b10;
    localparam logic [1:0] DIR_HAZARD = 2'b11;

    // RAM geometry
    localparam int RAM_AW = 4;
    localparam int RAM_DW = 4;

    // Glyphs {g,f,e,d,c,b,a}, active-high. Element 0 is the rightmost entry,
    // so the list reads from glyph F down to glyph 0.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG7_LUT[nibble];
    endfunction

    // Lamp pattern for each step of the turn-signal sequence: the lamps
    // light up one by one from the inside out, then all go dark.
    function automatic logic [2:0] dir_pattern(input logic [1:0] step);
        logic [2:0] pattern;
        case (step)
            2'd0:    pattern = 3'b000;
            2'd1:    pattern = 3'b001;
            2'd2:    pattern = 3'b011;
            default: pattern = 3'b111;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/playground_ram16x4.sv
// ---------------------------------------------------------------------------
// playground_ram16x4
//
// Purpose: 16 x 4 RAM with a synchronous write and a registered read.
// The read register loads mem[addr] on every enabled edge. When a write hits
// the same address, it returns the old data. The array itself has no reset.
// Only the read register is cleared.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset (clears the read register)
//   ena_i   in   clock enable; when low, the array and the read register hold
//   we_i    in   write enable
//   addr_i  in   [3:0] address
//   din_i   in   [3:0] write data
//   dout_o  out  [3:0] registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module playground_ram16x4
    import digital_playground_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [RAM_DW-1:0] din_i,
    output logic [RAM_DW-1:0] dout_o
);

    logic [RAM_DW-1:0] mem [2**RAM_AW];
    logic [RAM_DW-1:0] dout_q;
    logic [RAM_DW-1:0] dout_d;

    // Writes are blocked during reset so that a held reset cannot change
    // the stored contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ena_i && we_i) begin
            mem[addr_i] <= din_i;
        end
    end

    // The read path samples the array before this edge's write lands.
    // This gives read-old-data behaviour on a same-address write.
    always_comb begin
        dout_d = mem[addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else if (ena_i) begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/digital_playground_core.sv
// ---------------------------------------------------------------------------
// digital_playground_core
//
// Purpose: eight-mode teaching block in a Tiny-Tapeout-style wrapper.
// ui_in[2:0] selects one of these functions, and its result appears on uo_out:
//   000 gates, 001 mux/demux, 010 PWM, 011 hex-to-7-seg, 100 4-bit ALU,
//   101 frequency counter, 110 16x4 RAM, 111 turn-signal sequencer.
// All state runs continuously whatever the selected mode. The mode only
// steers the output mux.
//
// Build option: `define DIGITAL_PLAYGROUND_FDC_EN builds the frequency
// counter. Without it, the synchronizer and counter are absent and mode 101
// drives zero.
//
// Parameters:
//   DIR_DIV  turn-signal step period in clk cycles (>= 1)
//   FDC_W    frequency-counter width shown on uo_out (<= 8)
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset; uo_out is 0 while asserted
//   ena      in   enable; when low, every register holds its value
//   ui_in    in   [2:0] mode, [7:3] mode-specific controls
//   uio_in   in   mode-specific data
//   uo_out   out  mode result, unused bits 0
//   uio_out  out  constant 0
//   uio_oe   out  constant 0 (all uio pins are inputs)
// ---------------------------------------------------------------------------
module digital_playground_core
    import digital_playground_pkg::*;
#(
    parameter int DIR_DIV = 1,
    parameter int FDC_W   = 5
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0] mode;
    assign mode = ui_in[2:0];

    // -----------------------------------------------------------------------
    // Gates and mux/demux (purely combinational)
    // -----------------------------------------------------------------------
    logic       gateA;
    logic       gateB;
    logic [7:0] gatesOut;
    logic [7:0] mxdOut;
    logic [3:0] demux;

    assign gateA    = uio_in[0];
    assign gateB    = uio_in[1];
    assign gatesOut = {2'b00, ~gateA, ~(gateA | gateB), ~(gateA & gateB),
                       gateA ^ gateB, gateA | gateB, gateA & gateB};

    // The demux routes uio_in[2] to the output picked by ui_in[5:4].
    // Every other output stays 0.
    assign demux  = uio_in[2] ? (4'b0001 << ui_in[5:4]) : 4'b0000;
    assign mxdOut = {3'b000, demux, ui_in[3] ? uio_in[1] : uio_in[0]};

    // -----------------------------------------------------------------------
    // PWM: an 8-bit free-running counter compared against the duty value.
    // Duty 0 is always low, and duty 255 is low for one count out of 256.
    // -----------------------------------------------------------------------
    logic [7:0] pwmCnt_q;
    logic [7:0] pwmCnt_d;
    logic [7:0] pwmOut;

    always_comb begin
        pwmCnt_d = pwmCnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwmCnt_q <= '0;
        end else if (ena) begin
            pwmCnt_q <= pwmCnt_d;
        end
    end

    assign pwmOut = {7'b0, (pwmCnt_q < uio_in)};

    // -----------------------------------------------------------------------
    // Hex to 7-segment
    // -----------------------------------------------------------------------
    logic [7:0] hexOut;
    assign hexOut = {1'b0, hex_to_seg(uio_in[3:0])};

    // -----------------------------------------------------------------------
    // 4-bit ALU. Add and subtract are done 5 bits wide, so bit 4 is the
    // carry out for add and the borrow for subtract.
    // -----------------------------------------------------------------------
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [2:0] aluOp;
    logic [3:0] aluY;
    logic       aluFlag;
    logic [7:0] aluOut;

    assign aluA  = uio_in[3:0];
    assign aluB  = uio_in[7:4];
    assign aluOp = ui_in[5:3];

    always_comb begin
        aluY    = 4'd0;
        aluFlag = 1'b0;
        case (aluOp)
            ALU_ADD: {aluFlag, aluY} = {1'b0, aluA} + {1'b0, aluB};
            ALU_SUB: {aluFlag, aluY} = {1'b0, aluA} - {1'b0, aluB};
            ALU_AND: begin
                aluY    = aluA & aluB;
                aluFlag = (aluY == 4'd0);
            end
            ALU_OR: begin
                aluY    = aluA | aluB;
                aluFlag = (aluY == 4'd0);
            end
            ALU_XOR: begin
                aluY    = aluA ^ aluB;
                aluFlag = (aluY == 4'd0);
            end
            ALU_NOT: begin
                aluY    = ~aluA;
                aluFlag = (aluY == 4'd0);
            end
            ALU_SHL: begin
                aluY    = {aluA[2:0], 1'b0};
                aluFlag = aluA[3];
            end
            default: begin
                aluY    = 4'd0;
                aluFlag = (aluA == aluB);
            end
        endcase
    end

    assign aluOut = {3'b000, aluFlag, aluY};

    // -----------------------------------------------------------------------
    // Frequency counter: uio_in[0] passes through a 2-FF synchronizer, then a
    // rising-edge detector. Inputs faster than clk/2 alias, and that is
    // accepted.
    // -----------------------------------------------------------------------
    logic [FDC_W-1:0] fdcCount;

`ifdef DIGITAL_PLAYGROUND_FDC_EN
    logic             fdcSync1_q;
    logic             fdcSync2_q;
    logic             fdcPrev_q;
    logic             fdcRise;
    logic [FDC_W-1:0] fdcCnt_q;
    logic [FDC_W-1:0] fdcCnt_d;

    assign fdcRise = fdcSync2_q & ~fdcPrev_q;

    always_comb begin
        fdcCnt_d = fdcRise ? fdcCnt_q + FDC_W'(1) : fdcCnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fdcSync1_q <= 1'b0;
            fdcSync2_q <= 1'b0;
            fdcPrev_q  <= 1'b0;
            fdcCnt_q   <= '0;
        end else if (ena) begin
            fdcSync1_q <= uio_in[0];
            fdcSync2_q <= fdcSync1_q;
            fdcPrev_q  <= fdcSync2_q;
            fdcCnt_q   <= fdcCnt_d;
        end
    end

    assign fdcCount = fdcCnt_q;
`else
    assign fdcCount = '0;
`endif

    // -----------------------------------------------------------------------
    // 16x4 RAM
    // -----------------------------------------------------------------------
    logic [3:0] ramDout;

    playground_ram16x4 uRam (
        .clk_i  (clk),
        .rst_i  (rst),
        .ena_i  (ena),
        .we_i   (ui_in[7]),
        .addr_i (ui_in[6:3]),
        .din_i  (uio_in[3:0]),
        .dout_o (ramDout)
    );

    // -----------------------------------------------------------------------
    // Turn-signal sequencer. The step advances once every DIR_DIV cycles
    // while a direction is selected. Selecting "off" parks the step at 0.
    // Switching between active directions keeps the current step.
    // -----------------------------------------------------------------------
    localparam int DIV_W = (DIR_DIV > 1) ? $clog2(DIR_DIV) : 1;

    logic [1:0]       dirSel;
    logic [DIV_W-1:0] dirDiv_q;
    logic [DIV_W-1:0] dirDiv_d;
    logic [1:0]       dirStep_q;
    logic [1:0]       dirStep_d;
    logic             dirTick;
    logic [2:0]       dirLamps;
    logic [7:0]       dirOut;

    assign dirSel  = ui_in[4:3];
    assign dirTick = (dirDiv_q == DIV_W'(DIR_DIV - 1));

    always_comb begin
        dirDiv_d  = dirDiv_q;
        dirStep_d = dirStep_q;
        if (dirSel == DIR_OFF) begin
            dirDiv_d  = '0;
            dirStep_d = 2'd0;
        end else if (dirTick) begin
            dirDiv_d  = '0;
            dirStep_d = dirStep_q + 2'd1;
        end else begin
            dirDiv_d  = dirDiv_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dirDiv_q  <= '0;
            dirStep_q <= 2'd0;
        end else if (ena) begin
            dirDiv_q  <= dirDiv_d;
            dirStep_q <= dirStep_d;
        end
    end

    assign dirLamps = dir_pattern(dirStep_q);
    assign dirOut   = {1'b0, (dirSel[1] ? dirLamps : 3'b000),
                       1'b0, (dirSel[0] ? dirLamps : 3'b000)};

    // -----------------------------------------------------------------------
    // Output mux. Reset forces uo_out low whatever the selected mode.
    // -----------------------------------------------------------------------
    logic [7:0] modeOut;

    always_comb begin
        modeOut = 8'h00;
        case (mode)
            MODE_GATES: modeOut = gatesOut;
            MODE_MXD:   modeOut = mxdOut;
            MODE_PWM:   modeOut = pwmOut;
            MODE_HEX7:  modeOut = hexOut;
            MODE_ALU:   modeOut = aluOut;
            MODE_FDC:   modeOut = 8'(fdcCount);
            MODE_RAM:   modeOut = {4'b0000, ramDout};
            default:    modeOut = dirOut;
        endcase
    end

    assign uo_out  = rst ? 8'h00 : modeOut;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_digital_playground_core.sv
// ---------------------------------------------------------------------------
// tb_digital_playground_core
//
// Purpose: self-checking bench for digital_playground_core. Each scenario
// task pushes its expected results onto a scoreboard queue when it drives
// stimulus. It pops and compares them when the DUT output is sampled, at the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_digital_playground_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    typedef struct {
        string      name;
        logic [7:0] mask;
        logic [7:0] value;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    digital_playground_core #(
        .DIR_DIV (1),
        .FDC_W   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // 100 MHz bench clock
    always #5 clk = ~clk;

    // Reference lamp pattern for a turn-signal step
    function automatic logic [2:0] patOf(input int step);
        case (step)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Reset holds uo_out low, and the PWM counter must restart from 0
    task automatic test_reset();
        exp_t e;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h01;
        repeat (10) @(posedge clk);
        sbQ.push_back('{"reset_gates", 8'hFF, 8'h00});
        @(negedge clk);
        e = sbQ.pop_front();
        checks++;
        if ((uo_out & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
        end
        checks++;
        if ({uio_out, uio_oe} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL uio_const: got %h expected 0000", {uio_out, uio_oe});
        end
        ui_in  = 8'h02;
        uio_in = 8'h01;
        sbQ.push_back('{"reset_pwm", 8'hFF, 8'h00});
        #1;
        e = sbQ.pop_front();
        checks++;
        if ((uo_out & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.push_back('{"pwm_after_reset_cnt0", 8'hFF, 8'h01});
        sbQ.push_back('{"pwm_after_reset_cnt1", 8'hFF, 8'h00});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = sbQ.pop_front();
            checks++;
            if ((uo_out & e.mask) !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
            end
        end
    endtask

    // Every gate input pair, plus one mux/demux pattern
    task automatic test_gates_mux();
        exp_t e;
        logic a;
        logic b;
        for (int i = 0; i < 4; i++) begin
            a      = i[0];
            b      = i[1];
            ui_in  = 8'h00;
            uio_in = {6'b0, b, a};
            sbQ.push_back('{$sformatf("gates_a%0d_b%0d", a, b), 8'hFF,
                            {2'b00, ~a, ~(a | b), ~(a & b), a ^ b, a | b, a & b}});
            @(negedge clk);
            e = sbQ.pop_front();
            checks++;
            if ((uo_out & e.mask) !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
            end
        end
        ui_in  = 8'b0010_1001;
        uio_in = 8'h06;
        sbQ.push_back('{"mxd_sel1_demux2", 8'hFF, 8'b0000_1001});
        ui_in  = 8'b0011_0001;
        #1;
        e = sbQ.pop_front();
        ui_in  = 8'b0010_1001;
        @(negedge clk);
        checks++;
        if ((uo_out & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
        end
        ui_in  = 8'b0011_0001;
        uio_in = 8'h01;
        sbQ.push_back('{"mxd_sel0_demux3_off", 8'hFF, 8'b0000_0001});
        @(negedge clk);
        e = sbQ.pop_front();
        checks++;
        if ((uo_out & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
        end
    endtask

    // Count high samples over one full 256-cycle PWM period
    task automatic test_pwm();
        exp_t        e;
        int          highCount;
        logic [7:0]  duties [2];
        logic [7:0]  expectHigh [2];
        duties[0]     = 8'hAA;
        expectHigh[0] = 8'd170;
        duties[1]     = 8'h00;
        expectHigh[1] = 8'd0;
        for (int d = 0; d < 2; d++) begin
            ui_in  = 8'h02;
            uio_in = duties[d];
            sbQ.push_back('{$sformatf("pwm_duty_%02h", duties[d]), 8'hFF, expectHigh[d]});
            highCount = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                if (uo_out[0] === 1'b1) highCount++;
            end
            e = sbQ.pop_front();
            checks++;
            if ((8'(highCount) & e.mask) !== e.value || highCount > 255) begin
                failures++;
                $display("[TB] FAIL %s: got %0d high cycles expected %0d", e.name, highCount, e.value);
            end
        end
    endtask

    // Selected 7-segment glyphs
    task automatic test_hex();
        exp_t       e;
        logic [3:0] nib [4];
        logic [7:0] seg [4];
        nib[0] = 4'hA; seg[0] = 8'b0111_0111;
        nib[1] = 4'h8; seg[1] = 8'b0111_1111;
        nib[2] = 4'h0; seg[2] = 8'b0011_1111;
        nib[3] = 4'hB; seg[3] = 8'b0111_1100;
        for (int i = 0; i < 4; i++) begin
            ui_in  = 8'h03;
            uio_in = {4'hF, nib[i]};
            sbQ.push_back('{$sformatf("hex7_%h", nib[i]), 8'hFF, seg[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            checks++;
            if ((uo_out & e.mask) !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
            end
        end
    endtask

    // ALU operations, including the carry, borrow, shift and compare flags
    task automatic test_alu();
        exp_t       e;
        logic [3:0] av  [6];
        logic [3:0] bv  [6];
        logic [2:0] op  [6];
        logic [7:0] res [6];
        av[0] = 4'd9;  bv[0] = 4'd7;  op[0] = 3'b000; res[0] = 8'h10;
        av[1] = 4'd3;  bv[1] = 4'd5;  op[1] = 3'b001; res[1] = 8'h1E;
        av[2] = 4'd6;  bv[2] = 4'd6;  op[2] = 3'b111; res[2] = 8'h10;
        av[3] = 4'd5;  bv[3] = 4'd3;  op[3] = 3'b010; res[3] = 8'h01;
        av[4] = 4'hC;  bv[4] = 4'd0;  op[4] = 3'b110; res[4] = 8'h18;
        av[5] = 4'hF;  bv[5] = 4'd2;  op[5] = 3'b101; res[5] = 8'h10;
        for (int i = 0; i < 6; i++) begin
            ui_in  = {2'b00, op[i], 3'b100};
            uio_in = {bv[i], av[i]};
            sbQ.push_back('{$sformatf("alu_op%0d_a%h_b%h", op[i], av[i], bv[i]), 8'hFF, res[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            checks++;
            if ((uo_out & e.mask) !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
            end
        end
    endtask

    // RAM write, read latency, read-old-data and enable hold
    task automatic test_ram();
        exp_t       e;
        logic       we   [8];
        logic [3:0] addr [8];
        logic [3:0] din  [8];
        logic       en   [8];
        logic       chk  [8];
        logic [3:0] rd   [8];
        we[0]=1; addr[0]=4; din[0]=4'h5; en[0]=1; chk[0]=0; rd[0]=4'h0;
        we[1]=1; addr[1]=3; din[1]=4'hA; en[1]=1; chk[1]=0; rd[1]=4'h0;
        we[2]=0; addr[2]=3; din[2]=4'h0; en[2]=1; chk[2]=1; rd[2]=4'hA;
        we[3]=0; addr[3]=4; din[3]=4'h0; en[3]=1; chk[3]=1; rd[3]=4'h5;
        we[4]=1; addr[4]=3; din[4]=4'h6; en[4]=1; chk[4]=1; rd[4]=4'hA;
        we[5]=0; addr[5]=3; din[5]=4'h0; en[5]=1; chk[5]=1; rd[5]=4'h6;
        we[6]=1; addr[6]=3; din[6]=4'hF; en[6]=0; chk[6]=1; rd[6]=4'h6;
        we[7]=0; addr[7]=3; din[7]=4'h0; en[7]=1; chk[7]=1; rd[7]=4'h6;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ena    = en[i];
            ui_in  = {we[i], addr[i], 3'b110};
            uio_in = {4'h0, din[i]};
            if (chk[i]) sbQ.push_back('{$sformatf("ram_step%0d_addr%0d", i, addr[i]), 8'hFF, {4'h0, rd[i]}});
            @(posedge clk);
            @(negedge clk);
            if (chk[i]) begin
                e = sbQ.pop_front();
                checks++;
                if ((uo_out & e.mask) !== e.value) begin
                    failures++;
                    $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
                end
            end
        end
        ena = 1'b1;
    endtask

    // Turn-signal sequence through left, hazard, a hold with ena low, right and off
    task automatic test_dir();
        exp_t       e;
        int         step;
        logic [1:0] dirs [14];
        logic       ens  [14];
        logic [2:0] p;
        dirs[0]  = 2'b00; ens[0]  = 1;
        dirs[1]  = 2'b01; ens[1]  = 1;
        dirs[2]  = 2'b01; ens[2]  = 1;
        dirs[3]  = 2'b01; ens[3]  = 1;
        dirs[4]  = 2'b01; ens[4]  = 1;
        dirs[5]  = 2'b01; ens[5]  = 1;
        dirs[6]  = 2'b11; ens[6]  = 1;
        dirs[7]  = 2'b11; ens[7]  = 1;
        dirs[8]  = 2'b11; ens[8]  = 1;
        dirs[9]  = 2'b11; ens[9]  = 0;
        dirs[10] = 2'b11; ens[10] = 0;
        dirs[11] = 2'b10; ens[11] = 1;
        dirs[12] = 2'b10; ens[12] = 1;
        dirs[13] = 2'b00; ens[13] = 1;
        step = 0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            ena   = ens[i];
            ui_in = {3'b000, dirs[i], 3'b111};
            if (ens[i]) step = (dirs[i] == 2'b00) ? 0 : (step + 1) % 4;
            p = patOf(step);
            sbQ.push_back('{$sformatf("dir%b_cycle%0d", dirs[i], i), 8'hFF,
                            {1'b0, (dirs[i][1] ? p : 3'b000), 1'b0, (dirs[i][0] ? p : 3'b000)}});
            @(posedge clk);
            @(negedge clk);
            e = sbQ.pop_front();
            checks++;
            if ((uo_out & e.mask) !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, uo_out & e.mask, e.value);
            end
        end
        ena = 1'b1;
    endtask

    // Frequency counter with uio_in[0] toggling every 7 ns
    task automatic test_fdc();
        exp_t       e;
        logic [7:0] c8;
        logic [7:0] c24;
        @(negedge clk);
        ui_in  = 8'h05;
        uio_in = 8'h00;
        c8     = 8'h00;
        c24    = 8'h00;
        fork
            begin
                repeat (35) begin
                    #7;
                    uio_in[0] = ~uio_in[0];
                end
            end
            begin
                repeat (8) @(negedge clk);
                c8 = uo_out;
                repeat (16) @(negedge clk);
                c24 = uo_out;
            end
        join
`ifdef DIGITAL_PLAYGROUND_FDC_EN
        sbQ.push_back('{"fdc_count_changed", 8'hFF, 8'h01});
        e = sbQ.pop_front();
        checks++;
        if ({7'b0, (c24 != c8)} !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got c8=%h c24=%h expected different counts", e.name, c8, c24);
        end
        sbQ.push_back('{"fdc_upper_bits", 8'hE0, 8'h00});
        e = sbQ.pop_front();
        checks++;
        if ((c24 & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, c24 & e.mask, e.value);
        end
`else
        sbQ.push_back('{"fdc_disabled_c8", 8'hFF, 8'h00});
        sbQ.push_back('{"fdc_disabled_c24", 8'hFF, 8'h00});
        e = sbQ.pop_front();
        checks++;
        if ((c8 & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, c8 & e.mask, e.value);
        end
        e = sbQ.pop_front();
        checks++;
        if ((c24 & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, c24 & e.mask, e.value);
        end
`endif
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_gates_mux();
        test_pwm();
        test_hex();
        test_alu();
        test_ram();
        test_dir();
        test_fdc();
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
